// File: rtl/scope_pkg.sv
// Shared scope display constants and the pixel payload used across the display pipeline.
package scope_pkg;

    localparam int unsigned H_ACTIVE = 800;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned DATA_W   = 14;
    localparam int unsigned COORD_W  = 11;
    localparam int unsigned Y_SHIFT  = 5;
    localparam int unsigned GRID_X   = 100;
    localparam int unsigned GRID_Y   = 60;
    localparam int unsigned RGB_W    = 24;

    localparam logic [RGB_W-1:0] COL_TRACE = 24'hFFFF00;
    localparam logic [RGB_W-1:0] COL_AXIS  = 24'h808080;
    localparam logic [RGB_W-1:0] COL_GRID  = 24'h404040;
    localparam logic [RGB_W-1:0] COL_BG    = 24'h000000;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               valid;
    } pix_t;

endpackage

// File: rtl/graticule_gen.sv
// Division counters and grid/axis flags for the scan position; flags are registered one stage after pix.
module graticule_gen
    import scope_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  pix_t pix,
    output logic grid,
    output logic axis
);

    localparam int unsigned GX_W = 7;
    localparam int unsigned GY_W = 6;

    logic [GX_W-1:0]    gx_q;
    logic [GY_W-1:0]    gy_q;
    logic [COORD_W-1:0] last_y_q;
    logic [GX_W-1:0]    gx_c;
    logic [GY_W-1:0]    gy_c;

    // Division position of the current pixel; gx_q/gy_q hold the position expected next.
    always_comb begin
        gx_c = (pix.x == '0) ? '0 : gx_q;
        gy_c = gy_q;
        if (pix.y == '0) begin
            gy_c = '0;
        end else if (pix.y != last_y_q) begin
            gy_c = (gy_q == GY_W'(GRID_Y - 1)) ? '0 : gy_q + GY_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gx_q     <= '0;
            gy_q     <= '0;
            last_y_q <= '0;
            grid     <= 1'b0;
            axis     <= 1'b0;
        end else begin
            if (pix.valid) begin
                gx_q     <= (gx_c == GX_W'(GRID_X - 1)) ? '0 : gx_c + GX_W'(1);
                gy_q     <= gy_c;
                last_y_q <= pix.y;
            end
            grid <= (gx_c == '0) || (gy_c == '0) ||
                    (pix.x == COORD_W'(H_ACTIVE - 1)) || (pix.y == COORD_W'(V_ACTIVE - 1));
            axis <= (pix.x == COORD_W'(H_ACTIVE / 2)) || (pix.y == COORD_W'(V_ACTIVE / 2));
        end
    end

endmodule

// File: rtl/waveform_renderer.sv
// Renders the stored sample buffer as a joined trace over a graticule; fixed 4-clock pixel pipeline.
module waveform_renderer
    import scope_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic               pixel_valid,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] y_offset,
    output logic [COORD_W-1:0] sample_x,
    input  logic [DATA_W-1:0]  sample_data,
    output logic [RGB_W-1:0]   rgb_out,
    output logic               rgb_valid
);

    localparam int unsigned RAW_W = DATA_W - Y_SHIFT;
    localparam int unsigned TY_W  = 12;
    localparam int unsigned ROW_W = 9;

    logic [COORD_W-1:0] off_q, off_eff;
    pix_t               s1_pix, s2_pix;
    logic [COORD_W-1:0] s1_off, s2_off;
    logic [ROW_W-1:0]   ty_prev_q;
    logic               ty_valid_q;
    logic               s3_valid, s3_on, s3_in;
    logic               grid_q, axis_q;

    logic [RAW_W-1:0]   raw;
    logic [TY_W-1:0]    ty_s;
    logic [ROW_W-1:0]   ty_c, prev_c, lo_c, hi_c;
    logic               on_c, in_c;
    logic [RGB_W-1:0]   rgb_c;
    logic               unused_lsb;

    assign unused_lsb = ^sample_data[Y_SHIFT-1:0];
    assign off_eff    = frame_start ? y_offset : off_q;
    assign sample_x   = s1_pix.x;

    // Trace row for the sample now returning, clamped to the screen, joined to the previous column.
    always_comb begin
        raw  = sample_data[DATA_W-1:Y_SHIFT];
        ty_s = TY_W'(V_ACTIVE - 1) - {3'b000, raw} + {s2_off[COORD_W-1], s2_off};
        if (ty_s[TY_W-1]) begin
            ty_c = '0;
        end else if (ty_s > TY_W'(V_ACTIVE - 1)) begin
            ty_c = ROW_W'(V_ACTIVE - 1);
        end else begin
            ty_c = ROW_W'(ty_s);
        end
        prev_c = (ty_valid_q && (s2_pix.x != '0)) ? ty_prev_q : ty_c;
        lo_c   = (prev_c < ty_c) ? prev_c : ty_c;
        hi_c   = (prev_c < ty_c) ? ty_c : prev_c;
        on_c   = (s2_pix.y >= COORD_W'(lo_c)) && (s2_pix.y <= COORD_W'(hi_c));
        in_c   = (s2_pix.x < COORD_W'(H_ACTIVE)) && (s2_pix.y < COORD_W'(V_ACTIVE));
    end

    always_comb begin
        rgb_c = COL_BG;
        if (s3_in) begin
            if (s3_on) begin
                rgb_c = COL_TRACE;
            end else if (axis_q) begin
                rgb_c = COL_AXIS;
            end else if (grid_q) begin
                rgb_c = COL_GRID;
            end
        end
    end

    graticule_gen u_graticule (
        .clock (clock),
        .reset (reset),
        .pix   (s2_pix),
        .grid  (grid_q),
        .axis  (axis_q)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            off_q      <= '0;
            s1_pix     <= '0;
            s1_off     <= '0;
            s2_pix     <= '0;
            s2_off     <= '0;
            ty_prev_q  <= '0;
            ty_valid_q <= 1'b0;
            s3_valid   <= 1'b0;
            s3_on      <= 1'b0;
            s3_in      <= 1'b0;
            rgb_out    <= '0;
            rgb_valid  <= 1'b0;
        end else begin
            off_q    <= off_eff;
            s1_pix   <= '{x: pixel_x, y: pixel_y, valid: pixel_valid};
            s1_off   <= off_eff;
            s2_pix   <= s1_pix;
            s2_off   <= s1_off;
            if (s2_pix.valid) begin
                ty_prev_q  <= ty_c;
                ty_valid_q <= 1'b1;
            end
            s3_valid  <= s2_pix.valid;
            s3_on     <= on_c;
            s3_in     <= in_c;
            rgb_out   <= rgb_c;
            rgb_valid <= s3_valid;
        end
    end

endmodule

// File: doc/waveform_renderer.md
# waveform_renderer

Converts the captured sample buffer into display pixels for the 800×480 scope screen. Sits directly downstream of the sample/trigger stage: it drives that stage's column address from the display scan position, receives the stored 14-bit sample one clock later, and emits a pipelined RGB pixel stream. The output is a vertically scaled and offset trace joined column-to-column, over a graticule, for the LCD/VGA output block.

## Interface
- H_ACTIVE, 800, visible columns
- V_ACTIVE, 480, visible rows
- DATA_W, 14, sample width
- Y_SHIFT, 5, right-shift applied to sample before plotting
- GRID_X, 100, columns per horizontal division
- GRID_Y, 60, rows per vertical division

- clock  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- pixel_x  in  11  scan column
- pixel_y  in  11  scan row
- pixel_valid  in  1  scan position is inside the active area
- frame_start  in  1  one-cycle pulse at the start of each frame
- y_offset  in  11  signed vertical offset in rows; positive moves the trace down
- sample_x  out  11  column address to the sample stage
- sample_data  in  14  sample for sample_x, valid one clock after sample_x
- rgb_out  out  24  pixel colour {R,G,B}
- rgb_valid  out  1  rgb_out corresponds to a pixel_valid input

## Operation
- Offset register off_q:
  - Loaded from y_offset when frame_start=1; otherwise held.
  - A pixel presented in the same cycle as frame_start uses the new value.
- Trace row:
  - raw = sample_data >> Y_SHIFT, 9 bits, range 0..511.
  - ty = (V_ACTIVE-1) - raw + off_q, computed signed in 12 bits.
  - ty is clamped to 0..V_ACTIVE-1, so out-of-range samples draw on the top or bottom edge.
- Line join:
  - ty_prev holds ty of the previous valid pixel in the same row.
  - When pixel_x==0, or on the first valid pixel after reset, ty_prev := ty.
  - The pixel is on the trace if min(ty_prev,ty) ≤ y ≤ max(ty_prev,ty).
  - Invalid pixels do not update ty_prev.
- Graticule, computed with counters and no dividers:
  - gx resets to 0 at pixel_x==0, increments per valid pixel, and wraps GRID_X-1→0.
  - gy resets at pixel_y==0 and increments on each row change, wrapping GRID_Y-1→0.
  - grid = (gx==0 or gy==0 or x==H_ACTIVE-1 or y==V_ACTIVE-1).
  - axis = (x==H_ACTIVE/2 or y==V_ACTIVE/2).
- Colour priority:
  - trace 0xFFFF00
  - axis 0x808080
  - grid 0x404040
  - background 0x000000
- A valid pixel with pixel_x ≥ H_ACTIVE or pixel_y ≥ V_ACTIVE outputs background. sample_x still follows pixel_x.

## Timing
- Pipeline of 4 stages; the total latency from pixel input to rgb_out/rgb_valid is 4 clocks, fixed:
  - N: pixel in
  - N+1: sample_x = registered pixel_x
  - N+2: sample_data returned by the sample stage
  - N+3: ty and the line-join compare registered
  - N+4: rgb_out/rgb_valid registered
- pixel_x, pixel_y and pixel_valid are delayed internally to align with sample_data.
- Fully pipelined at one pixel per clock. There is no stall and no backpressure.
- Reset values:
  - rgb_out=0, rgb_valid=0, sample_x=0, off_q=0.
  - All pipeline valids, gx, gy and ty_prev are 0; the ty_prev-valid flag is 0.
- Reset mid-frame: rgb_valid stays 0 for 4 clocks after reset deasserts, even if pixel_valid=1.
- pixel_valid=0 gaps: the pipeline keeps advancing, rgb_valid=0 for the corresponding outputs, and ty_prev is preserved across the gap.

## Structure
- Shared package scope_pkg holds:
  - H_ACTIVE, V_ACTIVE, DATA_W
  - colour constants COL_TRACE, COL_AXIS, COL_GRID, COL_BG
- These are shared with the display timing and sample stages.
- One sub-module, graticule_gen: gx/gy counters plus grid/axis flags, aligned to the N+3 stage.
- Trace scaling, clamping and line join stay in the top module.

## Test plan
- Constant sample_data=0x0000, off=0: every valid pixel at row 479 is 0xFFFF00. Row 478, col 37 is background.
- Constant sample_data=0x3FFF, off=0: raw=511, ty clamps to 0, and row 0 is lit across all columns.
- Step from 0x1000 at col 9 to 0x2000 at col 10: ty goes 351→223. Col 10 lights rows 223..351 inclusive, and col 11 lights only row 223.
- y_offset=+40 applied with frame_start mid-frame: pixels before the pulse use the old offset, and all pixels from the pulse cycle onward are shifted 40 rows down.
- Pixel (400,100) with a trace elsewhere outputs 0x808080. Pixel (200,100) outputs 0x404040. Pixel (250,130) outputs 0x000000. Each appears exactly 4 clocks after input.
- Assert reset during active scan, then release: rgb_valid=0 for 4 clocks. The first valid pixel after release draws no line join from stale ty_prev.
